// File: rtl/line_memory_responder_pkg.sv
// line_memory_responder_pkg: LC-3b shared types plus the line-memory responder state and offset constant
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} lc3b_linemem_state;
  localparam int LC3B_LINE_OFFSET_BITS = 4;
endpackage

// File: rtl/line_memory_responder_storage.sv
// line_storage_array: LINES x 128 synchronous-write, registered-read line store, no reset
module line_storage_array
  import lc3b_types::*;
#(
  parameter int LINES = 16,
  localparam int IW = $clog2(LINES)
) (
  input  logic          clk,
  input  logic [IW-1:0] index,
  input  logic          write,
  input  lc3b_cacheline datain,
  output lc3b_cacheline dataout
);
  lc3b_cacheline mem [LINES];
  always_ff @(posedge clk) begin
    if (write) mem[index] <= datain;
    dataout <= mem[index];
  end
endmodule

// File: rtl/line_memory_responder.sv
// line_memory_responder: fixed-latency pmem responder serving 128-bit cacheline reads/writes
// Optional LINE_MEM_ERR_EN adds mem_err for read+write requests and out-of-range addresses.
module line_memory_responder
  import lc3b_types::*;
#(
  parameter int LATENCY = 4,
  parameter int LINES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_cacheline mem_wdata,
  output lc3b_cacheline mem_rdata,
  output logic          mem_resp
`ifdef LINE_MEM_ERR_EN
  ,
  output logic          mem_err
`endif
);
  localparam int IW = $clog2(LINES);
  lc3b_linemem_state state;
  logic [7:0] cnt;
  logic [IW-1:0] idx, addr_idx;
  logic op_write, req_err, req_bad, fire, unused_addr;
  lc3b_cacheline wdata, rd;
  assign addr_idx = mem_address[LC3B_LINE_OFFSET_BITS +: IW];
  assign unused_addr = ^mem_address;
`ifdef LINE_MEM_ERR_EN
  assign req_bad = ((mem_address >> (LC3B_LINE_OFFSET_BITS + IW)) != '0) || (mem_read && mem_write);
  assign mem_err = mem_resp & req_err;
`else
  assign req_bad = 1'b0;
`endif
  assign fire = state == BUSY && cnt == '0;
  // Array address follows the live request while idle so its registered read is ready by completion.
  line_storage_array #(.LINES(LINES)) u_store (
    .clk(clk),
    .index(state == IDLE ? addr_idx : idx),
    .write(fire && op_write && !req_err),
    .datain(wdata),
    .dataout(rd)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mem_resp <= 1'b0;
      mem_rdata <= '0;
      cnt <= '0;
      idx <= '0;
      op_write <= 1'b0;
      req_err <= 1'b0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE: if (mem_read || mem_write) begin
          idx <= addr_idx;
          op_write <= mem_write;
          req_err <= req_bad;
          wdata <= mem_wdata;
          cnt <= 8'(LATENCY - 1);
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == '0) begin
            state <= RESP;
            mem_resp <= 1'b1;
            if (req_err) mem_rdata <= '0;
            else if (!op_write) mem_rdata <= rd;
          end
        end
        RESP: begin
          mem_resp <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_memory_responder.sv
// tb_line_memory_responder: randomized and directed checks of line_memory_responder against a line-array model
module tb_line_memory_responder;
  localparam int LAT = 4;
`ifdef LINE_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0;
  logic [127:0] wd = '0;
  logic [127:0] rdata;
  logic resp;
  logic rd1 = 1'b0;
  logic [15:0] a1 = '0;
  logic [127:0] rdata1;
  logic resp1;
`ifdef LINE_MEM_ERR_EN
  logic err_o, err1;
`endif
  line_memory_responder #(.LATENCY(LAT), .LINES(16)) u4 (
    .clk(clk), .rst(rst), .mem_address(addr), .mem_read(rd), .mem_write(wr),
    .mem_wdata(wd), .mem_rdata(rdata), .mem_resp(resp)
`ifdef LINE_MEM_ERR_EN
    , .mem_err(err_o)
`endif
  );
  line_memory_responder #(.LATENCY(1), .LINES(16)) u1 (
    .clk(clk), .rst(rst), .mem_address(a1), .mem_read(rd1), .mem_write(1'b0),
    .mem_wdata(128'd0), .mem_rdata(rdata1), .mem_resp(resp1)
`ifdef LINE_MEM_ERR_EN
    , .mem_err(err1)
`endif
  );
  int total = 0, bad = 0;
  logic [127:0] mdl [16];
  logic [127:0] exp_rd = '0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic xact(input logic r, input logic w, input logic [15:0] a, input logic [127:0] d, input bit chg);
    int n = 0;
    logic e = ERR_EN && ((r && w) || a[15:8] != 8'd0);
    if (e) exp_rd = '0;
    else if (w) mdl[a[7:4]] = d;
    else exp_rd = mdl[a[7:4]];
    @(negedge clk);
    rd = r; wr = w; addr = a; wd = d;
    @(posedge clk); #1;
    if (chg) begin
      addr = 16'h0040;
      wd = ~d;
    end
    while (!resp && n < LAT + 5) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 128'(n), 128'(LAT));
    chk("rdata", rdata, exp_rd);
`ifdef LINE_MEM_ERR_EN
    chk("mem_err", 128'(err_o), 128'(e));
`endif
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk("resp_width", 128'(resp), 128'd0);
    @(posedge clk);
  endtask
  initial begin
    int cnt, last;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_resp", 128'(resp), 128'd0);
    chk("rst_rdata", rdata, 128'd0);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      cnt += int'(resp);
    end
    chk("idle_no_resp", 128'(cnt), 128'd0);
    for (int i = 0; i < 16; i++) xact(1'b0, 1'b1, 16'(i * 16), rnd_line(), 1'b0);
    xact(1'b0, 1'b1, 16'h0030, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0);
    xact(1'b1, 1'b0, 16'h0030, '0, 1'b0);
    xact(1'b1, 1'b0, 16'h0035, '0, 1'b0);
    xact(1'b0, 1'b1, 16'h0030, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1'b1);
    xact(1'b1, 1'b0, 16'h0040, '0, 1'b0);
    xact(1'b1, 1'b0, 16'h0030, '0, 1'b0);
    @(negedge clk);
    wr = 1'b1; addr = 16'h0010; wd = '1;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_resp", 128'(resp), 128'd0);
    chk("async_rst_rdata", rdata, 128'd0);
    wr = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      cnt += int'(resp);
    end
    chk("no_resp_after_rst", 128'(cnt), 128'd0);
    xact(1'b1, 1'b0, 16'h0010, '0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      int op = int'($urandom_range(0, 2));
      xact(op != 1, op != 0, 16'($urandom), rnd_line(), 1'b0);
    end
`ifdef LINE_MEM_ERR_EN
    xact(1'b0, 1'b1, 16'h1000, rnd_line(), 1'b0);
    xact(1'b1, 1'b0, 16'h0000, '0, 1'b0);
    xact(1'b1, 1'b1, 16'h0020, rnd_line(), 1'b0);
    xact(1'b1, 1'b0, 16'h0020, '0, 1'b0);
`endif
    @(negedge clk);
    rd1 = 1'b1;
    cnt = 0;
    last = -1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (resp1) begin
        cnt++;
        chk(last < 0 ? "lat1_first" : "lat1_gap", 128'(i - last), last < 0 ? 128'd2 : 128'd4);
        last = i;
      end
    end
    rd1 = 1'b0;
    chk("lat1_pulses", 128'(cnt), 128'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
